// File: rtl/id_stage_pipelined.sv
// Instruction-decode stage with its own ID/EX output register.
// Holds the register file, sign-extends the immediate, and resolves BEQ/BNE/J
// in ID, issuing a one-cycle registered PC redirect. A load-use hazard against
// the instruction in EX stalls the input side. The first instruction accepted
// after a taken branch/jump is on the wrong path and is squashed.
//
// Ports:
//   Clk, Reset (async, active-low)
//   in_valid/in_ready/in_instr/in_pc   : IF/ID side handshake and payload
//   wb_en/wb_sel/wb_data               : register-file write-back port
//   ex_load/ex_rt                      : load currently in EX (hazard source)
//   out_valid/out_ready/out_*          : ID/EX register and EX-side handshake
//   redirect_valid/redirect_pc         : registered fetch redirect pulse
//   stall_count                        : saturating hazard-stall cycle count
module id_stage_pipelined #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned REG_SELECT_WIDTH = 5,
    parameter int unsigned PC_WIDTH         = 32,
    parameter int unsigned STALL_CNT_WIDTH  = 16
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_instr,
    input  logic [PC_WIDTH-1:0]         in_pc,
    input  logic                        wb_en,
    input  logic [REG_SELECT_WIDTH-1:0] wb_sel,
    input  logic [DATA_WIDTH-1:0]       wb_data,
    input  logic                        ex_load,
    input  logic [REG_SELECT_WIDTH-1:0] ex_rt,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_rs_data,
    output logic [DATA_WIDTH-1:0]       out_rt_data,
    output logic [DATA_WIDTH-1:0]       out_imm,
    output logic [25:0]                 out_fields,
    output logic [5:0]                  out_opcode,
    output logic [PC_WIDTH-1:0]         out_pc,
    output logic                        redirect_valid,
    output logic [PC_WIDTH-1:0]         redirect_pc,
    output logic [STALL_CNT_WIDTH-1:0]  stall_count
);

    localparam int unsigned DEPTH = 2 ** REG_SELECT_WIDTH;
    localparam logic [5:0]  OP_J   = 6'b000010;
    localparam logic [5:0]  OP_BEQ = 6'b000100;
    localparam logic [5:0]  OP_BNE = 6'b000101;

    logic [DATA_WIDTH-1:0]       regs [DEPTH];
    logic                        squash;

    logic [REG_SELECT_WIDTH-1:0] rs_sel;
    logic [REG_SELECT_WIDTH-1:0] rt_sel;
    logic [DATA_WIDTH-1:0]       rs_data;
    logic [DATA_WIDTH-1:0]       rt_data;
    logic [DATA_WIDTH-1:0]       imm_ext;
    logic [PC_WIDTH-1:0]         branch_target;
    logic [PC_WIDTH-1:0]         jump_target;
    logic [PC_WIDTH-1:0]         target;
    logic                        hazard;
    logic                        accept;
    logic                        taken;

    assign rs_sel = REG_SELECT_WIDTH'(in_instr[25:21]);
    assign rt_sel = REG_SELECT_WIDTH'(in_instr[20:16]);

    // Register read with r0 forced to zero and same-cycle write-back bypass
    always_comb begin
        rs_data = regs[rs_sel];
        rt_data = regs[rt_sel];
        if (rs_sel == '0) begin
            rs_data = '0;
        end else if (wb_en && (wb_sel == rs_sel)) begin
            rs_data = wb_data;
        end
        if (rt_sel == '0) begin
            rt_data = '0;
        end else if (wb_en && (wb_sel == rt_sel)) begin
            rt_data = wb_data;
        end
    end

    // Load-use hazard; a wrong-path instruction never stalls
    always_comb begin
        hazard = 1'b0;
        if (in_valid && !squash && ex_load && (ex_rt != '0) &&
            ((ex_rt == rs_sel) || (ex_rt == rt_sel))) begin
            hazard = 1'b1;
        end
    end

    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Branch/jump resolution and target selection
    always_comb begin
        imm_ext       = {{(DATA_WIDTH-16){in_instr[15]}}, in_instr[15:0]};
        branch_target = in_pc + {{(PC_WIDTH-16){in_instr[15]}}, in_instr[15:0]};
        jump_target   = {in_pc[PC_WIDTH-1:26], in_instr[25:0]};
        target        = branch_target;
        taken         = 1'b0;
        unique case (in_instr[31:26])
            OP_BEQ:  taken = (rs_data == rt_data);
            OP_BNE:  taken = (rs_data != rt_data);
            OP_J: begin
                taken  = 1'b1;
                target = jump_target;
            end
            default: taken = 1'b0;
        endcase
    end

    // Register file; entry 0 is never written so it stays zero
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_sel != '0)) begin
            regs[wb_sel] <= wb_data;
        end
    end

    // ID/EX register, squash flag and redirect pulse
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            out_valid      <= 1'b0;
            out_rs_data    <= '0;
            out_rt_data    <= '0;
            out_imm        <= '0;
            out_fields     <= '0;
            out_opcode     <= '0;
            out_pc         <= '0;
            squash         <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= 1'b0;
            if (accept && !squash) begin
                out_valid   <= 1'b1;
                out_rs_data <= rs_data;
                out_rt_data <= rt_data;
                out_imm     <= imm_ext;
                out_fields  <= in_instr[25:0];
                out_opcode  <= in_instr[31:26];
                out_pc      <= in_pc;
                if (taken) begin
                    squash         <= 1'b1;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= target;
                end
            end else begin
                if (accept) begin
                    squash <= 1'b0;
                end
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    // Saturating count of cycles lost to load-use stalls
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_count <= '0;
        end else if (hazard && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: directed instructions push their
// expected ID/EX contents and redirect targets; a negedge monitor pops and
// compares whenever EX consumes an entry or a redirect pulse appears.
module tb_id_stage_pipelined;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [25:0] fields;
        logic [31:0] imm;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] pc;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        wb_en;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;
    logic        ex_load;
    logic [4:0]  ex_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs_data;
    logic [31:0] out_rt_data;
    logic [31:0] out_imm;
    logic [25:0] out_fields;
    logic [5:0]  out_opcode;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] stall_count;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    logic [31:0] redir_q[$];

    id_stage_pipelined dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .ex_load(ex_load), .ex_rt(ex_rt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
        .out_fields(out_fields), .out_opcode(out_opcode), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_count(stall_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, 6'h20};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] instr, input logic [31:0] rs_d,
                                    input logic [31:0] rt_d, input logic [31:0] pc);
        exp_t e;
        e.opcode  = instr[31:26];
        e.fields  = instr[25:0];
        e.imm     = {{16{instr[15]}}, instr[15:0]};
        e.rs_data = rs_d;
        e.rt_data = rt_d;
        e.pc      = pc;
        return e;
    endfunction

    // Monitor: compare consumed ID/EX entries and redirect pulses
    always @(negedge Clk) begin
        if (Reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {160'd0, out_pc}, 192'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_entry",
                          {32'd0, out_opcode, out_fields, out_imm, out_rs_data, out_rt_data, out_pc},
                          {32'd0, e});
                end
            end
            if (redirect_valid) begin
                if (redir_q.size() == 0) begin
                    check("unexpected_redirect", {160'd0, redirect_pc}, 192'd0);
                end else begin
                    logic [31:0] r;
                    r = redir_q.pop_front();
                    check("redirect_pc", {160'd0, redirect_pc}, {160'd0, r});
                end
            end
        end
    end

    task automatic idle();
        @(posedge Clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] sel, input logic [31:0] data);
        wb_en = 1'b1;
        wb_sel = sel;
        wb_data = data;
        idle();
        wb_en = 1'b0;
    endtask

    // Present one instruction and hold it until accepted (bounded)
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 192'd0, 192'd1);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        wb_en    = 1'b0;
    endtask

    logic [31:0] ins;

    initial begin
        Reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        wb_en = 1'b0; wb_sel = '0; wb_data = '0; ex_load = 1'b0; ex_rt = '0;
        out_ready = 1'b1;

        #12;
        check("rst_out_valid", {191'd0, out_valid}, 192'd0);
        check("rst_redirect", {159'd0, redirect_valid, redirect_pc}, 192'd0);
        check("rst_stall_count", {176'd0, stall_count}, 192'd0);
        check("rst_in_ready", {191'd0, in_ready}, 192'd1);
        @(negedge Clk);
        Reset = 1'b1;
        idle();

        wb(5'd1, 32'd7);
        wb(5'd2, 32'd7);
        wb(5'd0, 32'h55);
        wb(5'd5, 32'h55);

        // Write-through bypass: r3 written in the decode cycle; r0 stays zero
        ins = r_type(5'd3, 5'd0, 5'd5);
        exp_q.push_back(mk_exp(ins, 32'h0000_00AA, 32'd0, 32'h10));
        wb_en = 1'b1; wb_sel = 5'd3; wb_data = 32'h0000_00AA;
        issue(ins, 32'h10);
        idle();

        // Load-use stall for two cycles, r4 written during the stall
        ins = r_type(5'd1, 5'd4, 5'd6);
        in_valid = 1'b1; in_instr = ins; in_pc = 32'h20;
        ex_load = 1'b1; ex_rt = 5'd4;
        @(negedge Clk);
        check("stall1_in_ready", {191'd0, in_ready}, 192'd0);
        check("stall1_out_valid", {191'd0, out_valid}, 192'd0);
        idle();
        wb_en = 1'b1; wb_sel = 5'd4; wb_data = 32'h44;
        @(negedge Clk);
        check("stall2_in_ready", {191'd0, in_ready}, 192'd0);
        check("stall2_out_valid", {191'd0, out_valid}, 192'd0);
        idle();
        wb_en = 1'b0; ex_load = 1'b0;
        @(negedge Clk);
        check("stall_count", {176'd0, stall_count}, 192'd2);
        check("stall_release_ready", {191'd0, in_ready}, 192'd1);
        exp_q.push_back(mk_exp(ins, 32'd7, 32'h44, 32'h20));
        idle();
        in_valid = 1'b0;

        // Taken BEQ, squashed follower, then normal instruction
        ins = {6'b000100, 5'd1, 5'd2, 16'hFFFC};
        exp_q.push_back(mk_exp(ins, 32'd7, 32'd7, 32'h100));
        redir_q.push_back(32'h0000_00FC);
        issue(ins, 32'h100);
        issue(r_type(5'd1, 5'd2, 5'd7), 32'h101);
        check("beq_squash_out_valid", {191'd0, out_valid}, 192'd0);
        ins = r_type(5'd2, 5'd1, 5'd8);
        exp_q.push_back(mk_exp(ins, 32'd7, 32'd7, 32'h102));
        issue(ins, 32'h102);

        // Not-taken BNE: follower is not squashed
        ins = {6'b000101, 5'd1, 5'd2, 16'h0008};
        exp_q.push_back(mk_exp(ins, 32'd7, 32'd7, 32'h200));
        issue(ins, 32'h200);
        ins = r_type(5'd3, 5'd4, 5'd9);
        exp_q.push_back(mk_exp(ins, 32'h0000_00AA, 32'h44, 32'h201));
        issue(ins, 32'h201);

        // Jump keeps upper PC bits
        ins = {6'b000010, 26'h000_0123};
        exp_q.push_back(mk_exp(ins, 32'd0, 32'd0, 32'hF000_0010));
        redir_q.push_back(32'hF000_0123);
        issue(ins, 32'hF000_0010);
        issue(r_type(5'd4, 5'd4, 5'd4), 32'hF000_0011);
        check("j_squash_out_valid", {191'd0, out_valid}, 192'd0);
        ins = r_type(5'd4, 5'd1, 5'd3);
        exp_q.push_back(mk_exp(ins, 32'h44, 32'd7, 32'h300));
        issue(ins, 32'h300);
        idle();

        // Backpressure: hold A for three cycles while B waits
        out_ready = 1'b0;
        ins = r_type(5'd1, 5'd3, 5'd9);
        exp_q.push_back(mk_exp(ins, 32'd7, 32'h0000_00AA, 32'h400));
        issue(ins, 32'h400);
        ins = r_type(5'd2, 5'd3, 5'd10);
        in_valid = 1'b1; in_instr = ins; in_pc = 32'h401;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            check("bp_in_ready", {191'd0, in_ready}, 192'd0);
            check("bp_hold", {127'd0, out_valid, out_pc, out_rs_data},
                  {127'd0, 1'b1, 32'h400, 32'd7});
            idle();
        end
        out_ready = 1'b1;
        @(negedge Clk);
        check("bp_resume_ready", {191'd0, in_ready}, 192'd1);
        exp_q.push_back(mk_exp(ins, 32'd7, 32'h0000_00AA, 32'h401));
        idle();
        in_valid = 1'b0;
        idle();
        idle();

        // Asynchronous reset with an entry and a redirect in flight
        issue({6'b000100, 5'd1, 5'd2, 16'h0004}, 32'h500);
        #1;
        Reset = 1'b0;
        #1;
        check("async_rst_out", {94'd0, out_valid, redirect_valid, out_pc, out_rs_data, out_opcode},
              192'd0);
        check("async_rst_redirect_pc", {160'd0, redirect_pc}, 192'd0);
        check("async_rst_stall", {176'd0, stall_count}, 192'd0);
        @(negedge Clk);
        Reset = 1'b1;
        idle();
        ins = r_type(5'd5, 5'd1, 5'd2);
        exp_q.push_back(mk_exp(ins, 32'd0, 32'd0, 32'h600));
        issue(ins, 32'h600);
        idle();
        idle();
        idle();

        check("exp_queue_drained", {160'd0, 32'(exp_q.size())}, 192'd0);
        check("redir_queue_drained", {160'd0, 32'(redir_q.size())}, 192'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Parametrised instruction-decode stage with its own ID/EX output register; sits between the IF/ID register and EX.
- Holds the register file, sign-extends immediates, resolves BEQ/BNE/J in ID and issues a one-cycle PC redirect.
- Adds valid/ready handshakes, load-use stall and wrong-path squash.

Parameters:
DATA_WIDTH, 32, register and datapath width
REG_SELECT_WIDTH, 5, register index width; file depth = 2**REG_SELECT_WIDTH
PC_WIDTH, 32, PC width in words; must be >= 27
STALL_CNT_WIDTH, 16, width of saturating stall counter

Ports:
Clk  input  1  clock; all state updates on posedge
Reset  input  1  asynchronous, active-low reset
in_valid  input  1  IF/ID holds an instruction
in_ready  output  1  stage accepts the instruction this cycle
in_instr  input  32  instruction word
in_pc  input  PC_WIDTH  PC+1 of the instruction
wb_en  input  1  write-back enable
wb_sel  input  REG_SELECT_WIDTH  write-back register index
wb_data  input  DATA_WIDTH  write-back data
ex_load  input  1  instruction now in EX is a load
ex_rt  input  REG_SELECT_WIDTH  destination of that load
out_valid  output  1  ID/EX register holds a valid instruction
out_ready  input  1  EX consumes the ID/EX contents this cycle
out_rs_data  output  DATA_WIDTH  rs operand
out_rt_data  output  DATA_WIDTH  rt operand
out_imm  output  DATA_WIDTH  sign-extended instr[15:0]
out_fields  output  26  instr[25:0] (rs, rt, rd, shamt, funct)
out_opcode  output  6  instr[31:26]
out_pc  output  PC_WIDTH  in_pc carried forward
redirect_valid  output  1  one-cycle pulse: fetch from redirect_pc
redirect_pc  output  PC_WIDTH  branch or jump target
stall_count  output  STALL_CNT_WIDTH  saturating count of hazard-stall cycles

Behaviour:
- Reset low (asynchronous): all registers cleared to 0.
  - Affects every register-file entry, all out_* signals, redirect_valid/redirect_pc, stall_count and the squash flag.
  - Reset asserted mid-operation discards in-flight state.
  - First accept is possible in the first cycle after Reset is released.
- Register file:
  - Entry 0 reads 0 and ignores writes.
  - Write occurs on posedge when wb_en is high and wb_sel != 0.
  - Write-through: a read of wb_sel while wb_en is high (wb_sel != 0) returns wb_data in the same cycle.
- Hazard:
  - hazard = ex_load && ex_rt != 0 && (ex_rt == instr[25:21] || ex_rt == instr[20:16]).
  - Evaluated only when in_valid is high.
- Ready: in_ready = !hazard && (!out_valid || out_ready).
- Accept: accept = in_valid && in_ready.
- ID/EX register, updated on posedge:
  - Accept and squash flag clear: load all out_* fields; out_valid <= 1.
  - Otherwise, if out_ready: out_valid <= 0 (bubble). Data fields hold their values.
  - Otherwise: hold.
  - Latency is 1 cycle from accept to out_valid.
- Branch resolution, on an accepted, non-squashed instruction:
  - BEQ (opcode 000100) is taken if rs_data == rt_data (bypassed values).
  - BNE (opcode 000101) is taken if they differ.
  - J (opcode 000010) is always taken.
- Targets:
  - Branch: in_pc + sign-extended imm, modulo 2**PC_WIDTH; wrap-around permitted.
  - Jump: {in_pc[PC_WIDTH-1:26], instr[25:0]}.
- Redirect:
  - redirect_valid is registered: high exactly in the cycle after the taken accept, for one cycle.
  - redirect_pc is valid alongside it.
  - The taken branch or jump itself still enters ID/EX.
- Squash:
  - A taken accept sets the squash flag.
  - The next accepted instruction is consumed without entering ID/EX and without redirecting; this clears the flag.
  - A squashed instruction never triggers a redirect or a hazard stall. Its hazard term is masked, so in_ready = !out_valid || out_ready.
- stall_count: increments each cycle that in_valid && hazard; saturates at all-ones.
- Simultaneous events:
  - Hazard blocks acceptance even when out_ready is high; a bubble is emitted.
  - wb write to a stalled instruction's source becomes visible through the bypass in the same cycle.
- No combinational path from out_ready to out_* data.

Test Plan:
- Reset low mid-stream with out_valid=1 and redirect pending -> all outputs 0 immediately (asynchronous); reg r5 reads 0 after release.
- Write r3=0x0000_00AA via wb, same cycle decode ADD with rs=3 -> out_rs_data=0x0000_00AA next cycle; a write to r0 leaves r0 reading 0.
- ex_load=1, ex_rt=4, decode instr with rt=4 for 2 cycles -> in_ready=0 both cycles, out_valid=0 (bubbles), stall_count=2; instruction accepted on the third cycle once ex_load=0.
- BEQ r1,r2 with r1=r2=7, in_pc=0x100, imm=0xFFFC -> redirect_valid pulses one cycle with redirect_pc=0xFC; next accepted instruction squashed (out_valid stays 0 for it).
- BNE with equal operands -> no redirect, no squash; J with in_pc=0xF000_0010, instr[25:0]=0x0000123 -> redirect_pc=0xF000_0123.
- out_ready=0 with out_valid=1 and in_valid=1 -> in_ready=0, out_* held stable for 3 cycles; out_ready=1 -> accept resumes with no lost or duplicated instruction.
